// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of a 1W/1R register file between NUM_REQ requesters,
// with same-address read/write conflict alternation and ID-tagged 1-cycle read responses.
module regfile_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CELL_COUNT = 64,
  parameter int ADDR_WIDTH = $clog2(CELL_COUNT),
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             wr_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wr_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data_in,
  output logic [NUM_REQ-1:0]             wr_ready_out,
  input  logic [NUM_REQ-1:0]             rd_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rd_addr_in,
  output logic [NUM_REQ-1:0]             rd_ready_out,
  output logic                           rsp_valid_out,
  output logic [ID_WIDTH-1:0]            rsp_id_out,
  output logic [DATA_WIDTH-1:0]          rsp_data_out,
  output logic                           mem_w_en_out,
  output logic [ADDR_WIDTH-1:0]          mem_w_addr_out,
  output logic [DATA_WIDTH-1:0]          mem_w_data_out,
  output logic                           mem_r_en_out,
  output logic [ADDR_WIDTH-1:0]          mem_r_addr_out,
  input  logic [DATA_WIDTH-1:0]          mem_r_data_in
);
  logic [ID_WIDTH-1:0]   r_wr_ptr, r_rd_ptr, r_rsp_id;
  logic                  r_conflict, r_rsp_valid;
  logic [ID_WIDTH:0]     w_wr_pick, w_rd_pick;
  logic [ID_WIDTH-1:0]   w_wr_idx, w_rd_idx;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_conflict, w_wr_gnt, w_rd_gnt;

  // Returns {found, index} of the first valid requester at or after p, wrapping.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [ID_WIDTH-1:0] p);
    int j;
    logic [ID_WIDTH-1:0] jj;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      jj = ID_WIDTH'(j);
      if (v[jj]) rr_pick = {1'b1, jj};
    end
  endfunction

  function automatic logic [ID_WIDTH-1:0] nxt(input logic [ID_WIDTH-1:0] i);
    nxt = (i == ID_WIDTH'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    w_wr_pick      = rr_pick(wr_valid_in, r_wr_ptr);
    w_rd_pick      = rr_pick(rd_valid_in, r_rd_ptr);
    w_wr_idx       = w_wr_pick[ID_WIDTH-1:0];
    w_rd_idx       = w_rd_pick[ID_WIDTH-1:0];
    w_wr_addr      = wr_addr_in[int'(w_wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_rd_addr      = rd_addr_in[int'(w_rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_wr_data      = wr_data_in[int'(w_wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_conflict     = w_wr_pick[ID_WIDTH] & w_rd_pick[ID_WIDTH] & (w_wr_addr == w_rd_addr);
    w_wr_gnt       = rst & w_wr_pick[ID_WIDTH] & ~(w_conflict & r_conflict);
    w_rd_gnt       = rst & w_rd_pick[ID_WIDTH] & ~(w_conflict & ~r_conflict);
    wr_ready_out   = w_wr_gnt ? (NUM_REQ'(1) << w_wr_idx) : '0;
    rd_ready_out   = w_rd_gnt ? (NUM_REQ'(1) << w_rd_idx) : '0;
    mem_w_en_out   = w_wr_gnt;
    mem_w_addr_out = w_wr_gnt ? w_wr_addr : '0;
    mem_w_data_out = w_wr_gnt ? w_wr_data : '0;
    mem_r_en_out   = w_rd_gnt;
    mem_r_addr_out = w_rd_gnt ? w_rd_addr : '0;
    // Gating by rst drops a response that is in flight when reset arrives.
    rsp_valid_out  = r_rsp_valid & rst;
    rsp_id_out     = r_rsp_id;
    rsp_data_out   = rsp_valid_out ? mem_r_data_in : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_conflict  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      if (w_wr_gnt) r_wr_ptr <= nxt(w_wr_idx);
      if (w_rd_gnt) r_rd_ptr <= nxt(w_rd_idx);
      if (w_rd_gnt) r_rsp_id <= w_rd_idx;
      r_conflict  <= w_conflict & ~r_conflict;
      r_rsp_valid <= w_rd_gnt;
    end
  end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed bench with a behavioural register file and a response scoreboard.
module tb_regfile_port_arbiter;
  localparam int N = 2, AW = 6, DW = 32;
  logic            clk = 1'b0, rst;
  logic [N-1:0]    wr_valid, rd_valid, wr_ready, rd_ready;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;
  logic            rsp_valid, mem_w_en, mem_r_en;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_data, mem_w_data, mem_r_data;
  logic [AW-1:0]   mem_w_addr, mem_r_addr;
  logic [DW-1:0]   mem [64];
  int errors = 0, checks = 0, cyc = 0;
  typedef struct { int due; logic id; logic [DW-1:0] data; } exp_t;
  exp_t q[$];

  regfile_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CELL_COUNT(64)) dut (
    .clk(clk), .rst(rst),
    .wr_valid_in(wr_valid), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_ready_out(wr_ready),
    .rd_valid_in(rd_valid), .rd_addr_in(rd_addr), .rd_ready_out(rd_ready),
    .rsp_valid_out(rsp_valid), .rsp_id_out(rsp_id), .rsp_data_out(rsp_data),
    .mem_w_en_out(mem_w_en), .mem_w_addr_out(mem_w_addr), .mem_w_data_out(mem_w_data),
    .mem_r_en_out(mem_r_en), .mem_r_addr_out(mem_r_addr), .mem_r_data_in(mem_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    mem_r_data <= mem_r_en ? mem[mem_r_addr] : 'x;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    rd_valid[i] = 1'b1;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic idle();
    wr_valid = '0;
    rd_valid = '0;
  endtask

  task automatic push(input logic id, input logic [DW-1:0] d);
    q.push_back('{due: cyc + 1, id: id, data: d});
  endtask

  // Responses are due exactly one cycle after the grant that pushed them.
  always @(negedge clk) begin
    #3;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_id", 64'(rsp_id), 64'(e.id));
      chk("rsp_data", 64'(rsp_data), 64'(e.data));
    end else if (rsp_valid) chk("rsp_spurious", 64'(rsp_valid), 64'(0));
  end

  initial begin
    rst = 1'b0; wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr(0, 10, 32'h1010); wr(1, 11, 32'h1111); rd(0, 20); rd(1, 21);
    repeat (3) begin
      #1;
      chk("rst_wr_ready", 64'(wr_ready), 64'(0));
      chk("rst_rd_ready", 64'(rd_ready), 64'(0));
      chk("rst_mem_w_en", 64'(mem_w_en), 64'(0));
      chk("rst_mem_r_en", 64'(mem_r_en), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rel_wr_ready", 64'(wr_ready), 64'(1));
    chk("rel_rd_ready", 64'(rd_ready), 64'(1));
    chk("rel_mem_w_addr", 64'(mem_w_addr), 64'(10));
    chk("rel_mem_r_addr", 64'(mem_r_addr), 64'(20));
    push(1'b0, 32'h0);
    @(negedge clk);
    idle(); wr(1, 3, 32'hDEADBEEF);
    #1 chk("pre_wr_ready", 64'(wr_ready), 64'(2));
    @(negedge clk);
    idle(); wr(0, 5, 32'hA5); wr(1, 9, 32'hB9);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fair_wr_ready", 64'(wr_ready), k[0] ? 64'(2) : 64'(1));
      chk("fair_mem_w_addr", 64'(mem_w_addr), k[0] ? 64'(9) : 64'(5));
      chk("fair_mem_w_data", 64'(mem_w_data), k[0] ? 64'h0B9 : 64'h0A5);
      @(negedge clk);
    end
    idle(); rd(1, 3);
    #1;
    chk("lat_rd_ready", 64'(rd_ready), 64'(2));
    chk("lat_mem_r_en", 64'(mem_r_en), 64'(1));
    chk("lat_mem_r_addr", 64'(mem_r_addr), 64'(3));
    push(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    #1;
    chk("idle_mem_w_en", 64'(mem_w_en), 64'(0));
    chk("idle_mem_r_en", 64'(mem_r_en), 64'(0));
    chk("idle_wr_ready", 64'(wr_ready), 64'(0));
    @(negedge clk);
    wr(0, 7, 32'h11); rd(1, 7);
    #1;
    chk("cf_wr_ready", 64'(wr_ready), 64'(1));
    chk("cf_rd_ready", 64'(rd_ready), 64'(0));
    chk("cf_mem_r_en", 64'(mem_r_en), 64'(0));
    @(negedge clk);
    wr_valid = '0;
    #1;
    chk("cf2_rd_ready", 64'(rd_ready), 64'(2));
    chk("cf2_mem_r_addr", 64'(mem_r_addr), 64'(7));
    push(1'b1, 32'h11);
    @(negedge clk);
    idle(); rd(1, 2);
    for (int k = 0; k < 6; k++) begin
      if (!k[0]) wr(0, 2, 32'h100 + k);
      #1;
      chk("pc_wr_ready", 64'(wr_ready), k[0] ? 64'(0) : 64'(1));
      chk("pc_rd_ready", 64'(rd_ready), k[0] ? 64'(2) : 64'(0));
      if (k[0]) push(1'b1, 32'h100 + k - 1);
      @(negedge clk);
    end
    idle(); wr(1, 30, 32'h3030); rd(0, 10);
    #1;
    chk("da_wr_ready", 64'(wr_ready), 64'(2));
    chk("da_rd_ready", 64'(rd_ready), 64'(1));
    chk("da_mem_w_addr", 64'(mem_w_addr), 64'(30));
    chk("da_mem_r_addr", 64'(mem_r_addr), 64'(10));
    push(1'b0, 32'h1010);
    @(negedge clk);
    idle(); rd(0, 30);
    #1 chk("mr_rd_ready", 64'(rd_ready), 64'(1));
    @(negedge clk);
    idle(); rst = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mr_rsp_data", 64'(rsp_data), 64'(0));
    @(negedge clk);
    rst = 1'b1; rd(0, 40); rd(1, 41);
    #1 chk("mr_rd_ptr0", 64'(rd_ready), 64'(1));
    push(1'b0, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk);
    #5 chk("sb_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
